// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   state_t  : clear-sequencer states (ST_CLEAR while storage is being
//              zeroed, ST_READY once the file is usable)
//   depth_of : number of entries addressed by an ADDR_W-bit address
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
// Bundles the read/write buses of the multi-port register file.
//   wr_en       NUM_WR          per-port write enable
//   wr_addr     NUM_WR*ADDR_W   packed write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wr_data     NUM_WR*DATA_W   packed write data,      port k at [k*DATA_W +: DATA_W]
//   rd_addr     NUM_RD*ADDR_W   packed read addresses
//   rd_data     NUM_RD*DATA_W   packed read data (combinational)
//   ready       1               clear finished, file usable
//   wr_conf     1               registered pulse: write-address collision last cycle
//   dbg_state   state_t         clear-sequencer state
//   dbg_clr_idx ADDR_W          entry currently being cleared
//
// Handshake: there is no per-transfer valid/ready pair. A write on port k
// is taken on every rising edge where ready=1 and wr_en[k]=1; it can never
// be back-pressured. Read data is valid whenever ready=1 and is held at 0
// while ready=0.
// ---------------------------------------------------------------------------
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     ready;
   logic                     wr_conf;
   regfile_pkg::state_t      dbg_state;
   logic [ADDR_W-1:0]        dbg_clr_idx;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, ready, wr_conf, dbg_state, dbg_clr_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, ready, wr_conf, dbg_state, dbg_clr_idx
   );

endinterface

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file.
//   rd_addr  in   ADDR_W          address being read
//   mem_row  in   DATA_W          stored value at rd_addr
//   wr_en    in   NUM_WR          write enables of all write ports
//   wr_addr  in   NUM_WR*ADDR_W   packed write addresses
//   wr_data  in   NUM_WR*DATA_W   packed write data
//   ready    in   1               file usable; reads return 0 otherwise
//   rd_data  out  DATA_W          read result
// ---------------------------------------------------------------------------
module regfile_read_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]        mem_row,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     ready,
   output logic [DATA_W-1:0]        rd_data
);

   always_comb begin
      rd_data = mem_row;
      // Ascending scan: the last (highest-index) matching port overrides,
      // mirroring which write lands in storage at the edge.
      if (BYPASS != 0) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
               rd_data = wr_data[k*DATA_W +: DATA_W];
            end
         end
      end
      // Forcing zero last also covers the "entry not writable" case for the
      // bypass path, since the only non-writable entry is the zero register.
      if (!ready || ((ZERO_REG != 0) && (rd_addr == '0))) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// Parametrised multi-port GPR file: NUM_RD combinational read ports,
// NUM_WR write ports, optional hard-wired zero register, optional
// write-to-read bypass. After reset a sequencer zeroes one entry per
// cycle and raises ready when the whole array is clear.
//   clk    in  1        clock, all state on posedge
//   reset  in  1        synchronous, active-high
//   bus    regfile_if.slave  write/read buses, ready, wr_conf, debug state
// ---------------------------------------------------------------------------
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic     clk,
   input  logic     reset,
   regfile_if.slave bus
);

   localparam int                DEPTH    = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              ready;
   logic              collide;
   logic              wr_conf_q;

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == ST_CLEAR) begin
         clr_idx_d = clr_idx_q + ADDR_W'(1);
         if (clr_idx_q == LAST_IDX) begin
            state_d   = ST_READY;
            clr_idx_d = '0;
         end
      end
   end

   assign ready = (state_q == ST_READY);

   // ---------------- storage ----------------
   // No reset on the array itself: the sequencer clears it afterwards.
   // Ascending k so the highest-index port wins on a shared address.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
         end else begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (bus.wr_en[k] &&
                   ((ZERO_REG == 0) || (bus.wr_addr[k*ADDR_W +: ADDR_W] != '0))) begin
                  mem[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= bus.wr_data[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // ---------------- conflict detector ----------------
   // Only enabled ports are compared; the zero register still counts.
   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (bus.wr_en[i] && bus.wr_en[j] &&
                (bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W])) begin
               collide = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_conf_q <= 1'b0;
      end else begin
         wr_conf_q <= ready && collide;
      end
   end

   // ---------------- read ports ----------------
   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_word;

      assign ra = bus.rd_addr[j*ADDR_W +: ADDR_W];

      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .rd_addr (ra),
         .mem_row (mem[ra]),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .ready   (ready),
         .rd_data (rd_word)
      );

      assign bus.rd_data[j*DATA_W +: DATA_W] = rd_word;
   end

   assign bus.ready       = ready;
   assign bus.wr_conf     = wr_conf_q;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_clr_idx = clr_idx_q;

endmodule
